ipmred_encode_seq: RTL and testbench
====================================

# ipmred_encode_seq

Sequential IPM-RED encoder producing the share vector Z consumed by the IPM-RED arithmetic stages, including the constant multiplier and homogenization. It accepts one secret byte x per transaction, together with fresh randomness and the two public vectors L1 and L2. It produces a v-byte encoding in which (Z0, Z2..Zv-1) encodes x under L1 and (Z1, Z2..Zv-1) encodes x^3 under L2. One GF(2^8) multiply pair per cycle keeps the area small; a valid/ready handshake is used on both sides.

## Interface
- v, 8, number of shares; legal range v ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers x, R, L1, L2.
- in_ready  output  1  block can accept a new transaction.
- x  input  8  secret byte.
- R  input  max(v-2,1)*8  fresh random bytes; byte i (bits 8i+7:8i) becomes share Z(i+2); unused when v=2.
- L1  input  v*8  IPM vector for x; byte j is the coefficient of Zj; bytes 0 and 1 are ignored (Z0 coefficient is implicitly 1).
- L2  input  v*8  IPM vector for x^3; byte j is the coefficient of Zj; bytes 0 and 1 are ignored (Z1 coefficient is implicitly 1).
- out_valid  output  1  Z is valid.
- out_ready  input  1  downstream accepts Z.
- Z  output  v*8  encoding; share j is at bits 8j+7:8j.

## Operation
- Field: GF(2^8), polynomial x^8+x^4+x^3+x+1 (0x11B). Addition is XOR. All products are reduced to 8 bits.
- Encoding, for j = 2..v-1:
  - Zj = R byte (j-2).
  - Z0 = x ^ XOR_j (L1[j]·Zj).
  - Z1 = x^3 ^ XOR_j (L2[j]·Zj).
- Resources: two combinational GF(2^8) multipliers, MA and MB. MA also computes the cube. No other multipliers are used.
- Input handling: x, R, L1 and L2 are captured into internal registers on the input handshake (in_valid & in_ready). After capture, input ports are don't-care until the next handshake.
- FSM states: IDLE, SQ, CB, ACC, DONE.
  - IDLE: in_ready=1. On handshake, capture inputs, set acc0=x, set j=2, go to SQ.
  - SQ: MA computes x·x into register sq. Go to CB.
  - CB: MA computes sq·x; acc1 ← sq·x. If v=2, go to DONE; otherwise go to ACC.
  - ACC: acc0 ^= MA(L1[j], Zj) and acc1 ^= MB(L2[j], Zj). Increment j. After j = v-1 has been processed, go to DONE.
  - DONE: out_valid=1. Z = {R bytes, acc1, acc0}. On out_valid & out_ready, go to IDLE.
- Counter j is ceil(log2(v))+1 bits wide. It never wraps within a transaction.
- Share order is fixed: byte 0 is acc0, byte 1 is acc1, bytes 2..v-1 are the captured R.

## Timing
- Reset values: in_ready=1, out_valid=0, Z=0, state IDLE, and all internal registers 0.
- Reset asserted in any state aborts the transaction immediately and discards captured data. The first acceptance is possible at the first rising edge after rst deasserts.
- Latency: if the input handshake occurs at edge k, out_valid is 1 from just after edge k+v. This holds for every v ≥ 2, including v=2, where CB goes directly to DONE.
- in_ready is 1 only in IDLE. in_ready is combinational from state only and does not depend on in_valid.
- Backpressure: while out_valid=1 and out_ready=0, Z and out_valid remain stable for any number of cycles.
- After the output handshake at edge m, in_ready=1 from just after edge m. Minimum transaction period is v+2 cycles.
- out_ready asserted outside DONE has no effect. in_valid asserted outside IDLE is ignored and not captured.
- Z is registered. Z updates only when acc0/acc1 are written, and is held in DONE.

## Test plan
- Reset: assert rst mid-ACC with v=4 → out_valid=0, in_ready=1, Z=0 immediately. After release, a new transaction completes correctly.
- v=2, x=0x02 → Z0=0x02, Z1=0x08. out_valid rises 2 cycles after acceptance. Repeat with x=0x03 → Z0=0x03, Z1=0x0F.
- v=3, x=0x02, R=0x87, L1[2]=0x02, L2[2]=0x03 → Z = {0x87, 0x9A, 0x17} (bytes 2,1,0). out_valid rises 3 cycles after acceptance.
- v=8 with random x, R, L1, L2 (500 transactions) versus a reference model. Check ⟨(1,L1[2..]),(Z0,Z2..)⟩=x and ⟨(1,L2[2..]),(Z1,Z2..)⟩=x^3. Check latency is exactly 8 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → Z and out_valid stable and in_ready=0. Toggle in_valid and x during the stall → no capture.
- Back-to-back: keep in_valid=1 and out_ready=1 continuously with v=4 → one result every 6 cycles, all results correct and in order.

Source files
------------

// File: rtl/ipmred_encode_seq_if.sv
// Handshake bundle for the IPM-RED encoder: input transaction (x, R, L1, L2)
// and output share vector Z, each with its own valid/ready pair.
interface ipmred_encode_seq_if #(
  parameter int V = 8
);
  localparam int RW = ((V > 2) ? (V - 2) : 1) * 8;

  logic            in_valid;
  logic            in_ready;
  logic [7:0]      x;
  logic [RW-1:0]   R;
  logic [V*8-1:0]  L1;
  logic [V*8-1:0]  L2;
  logic            out_valid;
  logic            out_ready;
  logic [V*8-1:0]  Z;

  modport master (
    output in_valid, x, R, L1, L2, out_ready,
    input  in_ready, out_valid, Z
  );

  modport slave (
    input  in_valid, x, R, L1, L2, out_ready,
    output in_ready, out_valid, Z
  );
endinterface

// File: rtl/ipmred_encode_seq.sv
// Sequential IPM-RED encoder: Z0 encodes x under L1, Z1 encodes x^3 under L2,
// Z2..Zv-1 are the fresh random bytes. One GF(2^8) multiply pair per cycle.
module ipmred_encode_seq #(
  parameter int V = 8
) (
  input  logic               clk,
  input  logic               rst,
  ipmred_encode_seq_if.slave bus
);
  localparam int RW = ((V > 2) ? (V - 2) : 1) * 8;
  localparam int NR = (V > 2) ? (V - 2) : 1;
  localparam int JW = $clog2(V) + 1;

  typedef enum logic [2:0] {IDLE, SQ, CB, ACC, DONE} state_t;

  state_t        state;
  logic          out_valid_r;
  logic [7:0]    x_r;
  logic [7:0]    sq;
  logic [7:0]    acc0;
  logic [7:0]    acc1;
  logic [RW-1:0] r_r;
  logic [RW-1:0] l1_r;
  logic [RW-1:0] l2_r;
  logic [JW-1:0] j;
  logic [JW-1:0] k;

  logic [RW-1:0] l1_in;
  logic [RW-1:0] l2_in;
  logic [7:0]    sel_r;
  logic [7:0]    sel_l1;
  logic [7:0]    sel_l2;
  logic [7:0]    ma_a;
  logic [7:0]    ma_b;
  logic [7:0]    mb_a;
  logic [7:0]    mb_b;
  logic [7:0]    ma_p;
  logic [7:0]    mb_p;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add with reduction)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Only coefficient bytes 2..v-1 are meaningful; bytes 0/1 are implicit ones.
  if (V > 2) begin : g_wide
    logic unused_low;
    assign l1_in      = bus.L1[V*8-1:16];
    assign l2_in      = bus.L2[V*8-1:16];
    assign bus.Z      = {r_r, acc1, acc0};
    assign unused_low = ^{bus.L1[15:0], bus.L2[15:0]};
  end else begin : g_narrow
    logic unused_all;
    assign l1_in      = '0;
    assign l2_in      = '0;
    assign bus.Z      = {acc1, acc0};
    assign unused_all = ^{bus.R, bus.L1, bus.L2, r_r, l1_r, l2_r, sel_r, sel_l1, sel_l2};
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;

  assign k = j - JW'(2);

  always_comb begin
    sel_r  = 8'h00;
    sel_l1 = 8'h00;
    sel_l2 = 8'h00;
    for (int i = 0; i < NR; i++) begin
      if (k == JW'(i)) begin
        sel_r  = r_r[i*8 +: 8];
        sel_l1 = l1_r[i*8 +: 8];
        sel_l2 = l2_r[i*8 +: 8];
      end
    end
  end

  // MA is shared between squaring, cubing and the L1 accumulation
  always_comb begin
    ma_a = 8'h00;
    ma_b = 8'h00;
    mb_a = 8'h00;
    mb_b = 8'h00;
    case (state)
      SQ: begin
        ma_a = x_r;
        ma_b = x_r;
      end
      CB: begin
        ma_a = sq;
        ma_b = x_r;
      end
      ACC: begin
        ma_a = sel_l1;
        ma_b = sel_r;
        mb_a = sel_l2;
        mb_b = sel_r;
      end
      default: ;
    endcase
    ma_p = gf_mul(ma_a, ma_b);
    mb_p = gf_mul(mb_a, mb_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_r <= 1'b0;
      x_r         <= 8'h00;
      sq          <= 8'h00;
      acc0        <= 8'h00;
      acc1        <= 8'h00;
      r_r         <= '0;
      l1_r        <= '0;
      l2_r        <= '0;
      j           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_r   <= bus.x;
            r_r   <= bus.R;
            l1_r  <= l1_in;
            l2_r  <= l2_in;
            acc0  <= bus.x;
            j     <= JW'(2);
            state <= SQ;
          end
        end
        SQ: begin
          sq    <= ma_p;
          state <= CB;
        end
        CB: begin
          acc1 <= ma_p;
          if (V == 2) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            state <= ACC;
          end
        end
        ACC: begin
          acc0 <= acc0 ^ ma_p;
          acc1 <= acc1 ^ mb_p;
          j    <= j + JW'(1);
          if (j == JW'(V - 1)) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ipmred_encode_seq.sv
// Bench for ipmred_encode_seq: four instances (v = 2, 3, 4, 8) driven from one
// sequence and compared against a field-arithmetic model of the encoding.
module tb_ipmred_encode_seq;
  logic        clk;
  logic        rst;
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [7:0]  x_d;
  logic [47:0] r_d;
  logic [63:0] l1_d;
  logic [63:0] l2_d;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [63:0] zz [4];
  int          vv [4];
  int          tests;
  int          fails;

  ipmred_encode_seq_if #(.V(2)) b2 ();
  ipmred_encode_seq_if #(.V(3)) b3 ();
  ipmred_encode_seq_if #(.V(4)) b4 ();
  ipmred_encode_seq_if #(.V(8)) b8 ();

  ipmred_encode_seq #(.V(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  ipmred_encode_seq #(.V(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  ipmred_encode_seq #(.V(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  ipmred_encode_seq #(.V(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  assign b2.in_valid = iv[0];   assign b2.out_ready = ordy[0];
  assign b3.in_valid = iv[1];   assign b3.out_ready = ordy[1];
  assign b4.in_valid = iv[2];   assign b4.out_ready = ordy[2];
  assign b8.in_valid = iv[3];   assign b8.out_ready = ordy[3];
  assign b2.x = x_d;  assign b2.R = r_d[7:0];   assign b2.L1 = l1_d[15:0]; assign b2.L2 = l2_d[15:0];
  assign b3.x = x_d;  assign b3.R = r_d[7:0];   assign b3.L1 = l1_d[23:0]; assign b3.L2 = l2_d[23:0];
  assign b4.x = x_d;  assign b4.R = r_d[15:0];  assign b4.L1 = l1_d[31:0]; assign b4.L2 = l2_d[31:0];
  assign b8.x = x_d;  assign b8.R = r_d;        assign b8.L1 = l1_d;       assign b8.L2 = l2_d;
  assign ir = {b8.in_ready, b4.in_ready, b3.in_ready, b2.in_ready};
  assign ov = {b8.out_valid, b4.out_valid, b3.out_valid, b2.out_valid};
  assign zz[0] = {48'h0, b2.Z};
  assign zz[1] = {40'h0, b3.Z};
  assign zz[2] = {32'h0, b4.Z};
  assign zz[3] = b8.Z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product followed by long division by 0x11B
  function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] fcube(input logic [7:0] a);
    return fmul(fmul(a, a), a);
  endfunction

  function automatic logic [63:0] ref_z(input int v, input logic [7:0] xv, input logic [47:0] r,
                                       input logic [63:0] l1, input logic [63:0] l2);
    logic [7:0]  sh [8];
    logic [63:0] o;
    for (int i = 0; i < 8; i++) sh[i] = 8'h00;
    sh[0] = xv;
    sh[1] = fcube(xv);
    for (int jj = 2; jj < v; jj++) begin
      sh[jj] = r[(jj-2)*8 +: 8];
      sh[0]  = sh[0] ^ fmul(l1[jj*8 +: 8], sh[jj]);
      sh[1]  = sh[1] ^ fmul(l2[jj*8 +: 8], sh[jj]);
    end
    o = 64'h0;
    for (int i = 0; i < v; i++) o[i*8 +: 8] = sh[i];
    return o;
  endfunction

  // Inner product <(1, l[2..]), (z[base], z[2..])>
  function automatic logic [7:0] ipf(input int v, input logic [63:0] l, input logic [63:0] z, input int base);
    logic [7:0] acc;
    acc = z[base*8 +: 8];
    for (int jj = 2; jj < v; jj++) acc = acc ^ fmul(l[jj*8 +: 8], z[jj*8 +: 8]);
    return acc;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    x_d  = 8'($urandom);
    r_d  = 48'({$urandom, $urandom});
    l1_d = {$urandom, $urandom};
    l2_d = {$urandom, $urandom};
  endtask

  task automatic run_txn(input int s, input logic [7:0] xv, input logic [47:0] r,
                         input logic [63:0] l1, input logic [63:0] l2, input string tag,
                         output logic [63:0] zo);
    int          cnt;
    logic [63:0] exp;
    x_d = xv; r_d = r; l1_d = l1; l2_d = l2;
    iv[s]   = 1'b1;
    ordy[s] = 1'b1;
    check({tag, "_in_ready"}, 64'(ir[s]), 64'd1);
    tick;
    iv[s] = 1'b0;
    scramble();
    cnt = 0;
    while (!ov[s] && cnt < 40) begin
      tick;
      cnt++;
    end
    zo  = zz[s];
    exp = ref_z(vv[s], xv, r, l1, l2);
    check({tag, "_latency"}, 64'(cnt), 64'(vv[s]));
    check({tag, "_z"}, zo, exp);
    check({tag, "_ip1"}, 64'(ipf(vv[s], l1, zo, 0)), 64'(xv));
    check({tag, "_ip2"}, 64'(ipf(vv[s], l2, zo, 1)), 64'(fcube(xv)));
    tick;
    check({tag, "_ov_clr"}, 64'(ov[s]), 64'd0);
    check({tag, "_ir_back"}, 64'(ir[s]), 64'd1);
    ordy[s] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]       zo;
    logic [63:0]       zhold;
    logic [63:0]       exp;
    logic [7:0]        xv;
    logic [47:0]       rv;
    logic [63:0]       l1v;
    logic [63:0]       l2v;
    logic [63:0]       q[$];
    int                cyc;
    int                last;
    int                n_in;
    int                n_out;

    tests = 0; fails = 0;
    vv[0] = 2; vv[1] = 3; vv[2] = 4; vv[3] = 8;
    iv = 4'h0; ordy = 4'h0;
    x_d = 8'h0; r_d = 48'h0; l1_d = 64'h0; l2_d = 64'h0;
    rst = 1'b1;
    repeat (3) tick;
    for (int s = 0; s < 4; s++) begin
      check("rst_in_ready", 64'(ir[s]), 64'd1);
      check("rst_out_valid", 64'(ov[s]), 64'd0);
      check("rst_z", zz[s], 64'h0);
    end
    rst = 1'b0;

    run_txn(0, 8'h02, 48'h0, 64'h0, 64'h0, "v2_x02", zo);
    check("v2_x02_const", zo, 64'h0802);
    run_txn(0, 8'h03, 48'h0, 64'h0, 64'h0, "v2_x03", zo);
    check("v2_x03_const", zo, 64'h0F03);

    run_txn(1, 8'h02, 48'h87, 64'h02_55AA, 64'h03_1234, "v3_vec", zo);
    check("v3_vec_const", zo, 64'h879A17);

    // Abort a v=4 transaction in ACC with an asynchronous reset
    x_d = 8'h5C; r_d = 48'h1234; l1_d = 64'h0A0B_0000; l2_d = 64'h0C0D_0000;
    iv[2] = 1'b1; ordy[2] = 1'b0;
    tick;
    iv[2] = 1'b0;
    tick;
    tick;
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(ov[2]), 64'd0);
    check("abort_in_ready", 64'(ir[2]), 64'd1);
    check("abort_z", zz[2], 64'h0);
    #1 rst = 1'b0;
    run_txn(2, 8'hA7, 48'hBEEF, 64'h3344_0000, 64'h5566_0000, "post_abort", zo);

    for (int t = 0; t < 500; t++) begin
      xv  = 8'($urandom);
      rv  = 48'({$urandom, $urandom});
      l1v = {$urandom, $urandom};
      l2v = {$urandom, $urandom};
      run_txn(3, xv, rv, l1v, l2v, "v8_rand", zo);
    end

    // Backpressure on v=8 with noise on in_valid and x during the stall
    xv = 8'hC3; rv = 48'h0102_0304_0506; l1v = {$urandom, $urandom}; l2v = {$urandom, $urandom};
    x_d = xv; r_d = rv; l1_d = l1v; l2_d = l2v;
    iv[3] = 1'b1; ordy[3] = 1'b0;
    tick;
    iv[3] = 1'b0;
    cyc = 0;
    while (!ov[3] && cyc < 40) begin
      tick;
      cyc++;
    end
    check("bp_latency", 64'(cyc), 64'd8);
    zhold = zz[3];
    check("bp_z", zhold, ref_z(8, xv, rv, l1v, l2v));
    for (int t = 0; t < 10; t++) begin
      iv[3] = 1'($urandom);
      x_d   = 8'($urandom);
      tick;
      check("bp_z_stable", zz[3], zhold);
      check("bp_ov_held", 64'(ov[3]), 64'd1);
      check("bp_ir_low", 64'(ir[3]), 64'd0);
    end
    iv[3] = 1'b0;
    ordy[3] = 1'b1;
    tick;
    ordy[3] = 1'b0;
    check("bp_release_ov", 64'(ov[3]), 64'd0);
    check("bp_release_ir", 64'(ir[3]), 64'd1);

    // Back-to-back v=4 with both handshakes held high
    iv[2] = 1'b1; ordy[2] = 1'b1;
    cyc = 0; last = -1; n_in = 0; n_out = 0;
    while (n_out < 8 && cyc < 200) begin
      if (ir[2]) begin
        if (n_in < 8) begin
          scramble();
          q.push_back(ref_z(4, x_d, r_d, l1_d, l2_d));
          n_in++;
        end else begin
          iv[2] = 1'b0;
        end
      end
      if (ov[2]) begin
        exp = (q.size() > 0) ? q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check("b2b_z", zz[2], exp);
        if (last >= 0) check("b2b_period", 64'(cyc - last), 64'd6);
        last = cyc;
        n_out++;
      end
      tick;
      cyc++;
    end
    check("b2b_count", 64'(n_out), 64'd8);
    iv[2] = 1'b0; ordy[2] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
